// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32I/RV32M execute-stage ALU with valid/ready on issue and result sides.
// One radix-2 datapath (acc/quo/dvs) does shift-add multiply and restoring divide.
module alu_seq #(
    parameter  int DATA_W = 32,
    localparam int SH_W   = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [4:0]        i_alu_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_alu_data
);

    localparam int CNT_W = SH_W + 1;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_OPB    = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;      // product high half / partial remainder
    logic [DATA_W-1:0]   quo_q, quo_d;      // multiplier / dividend shifting into quotient
    logic [DATA_W-1:0]   dvs_q, dvs_d;      // multiplicand / divisor magnitude
    logic [4:0]          op_q, op_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                accept;
    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   alu_res;
    logic                is_mul, is_div;
    logic                a_signed, b_signed, a_neg, b_neg, div_ovf;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   q_fix, r_fix;

    assign o_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
    assign o_valid    = (state_q == S_DONE);
    assign o_alu_data = result_q;
    assign accept     = i_valid && o_ready && !i_flush;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        shamt   = i_operand_b[SH_W-1:0];
        alu_res = '0;
        case (i_alu_op)
            OP_ADD:  alu_res = i_operand_a + i_operand_b;
            OP_SUB:  alu_res = i_operand_a - i_operand_b;
            OP_SLL:  alu_res = i_operand_a << shamt;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(i_operand_a) < $signed(i_operand_b)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, i_operand_a < i_operand_b};
            OP_XOR:  alu_res = i_operand_a ^ i_operand_b;
            OP_SRL:  alu_res = i_operand_a >> shamt;
            OP_SRA:  alu_res = $signed(i_operand_a) >>> shamt;
            OP_OR:   alu_res = i_operand_a | i_operand_b;
            OP_AND:  alu_res = i_operand_a & i_operand_b;
            OP_OPB:  alu_res = i_operand_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        is_mul   = (i_alu_op >= OP_MUL) && (i_alu_op <= OP_MULHU);
        is_div   = (i_alu_op >= OP_DIV) && (i_alu_op <= OP_REMU);
        a_signed = (i_alu_op == OP_MULH) || (i_alu_op == OP_MULHSU) ||
                   (i_alu_op == OP_DIV)  || (i_alu_op == OP_REM);
        b_signed = (i_alu_op == OP_MULH) || (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
        a_neg    = a_signed && i_operand_a[DATA_W-1];
        b_neg    = b_signed && i_operand_b[DATA_W-1];
        a_mag    = a_neg ? -i_operand_a : i_operand_a;
        b_mag    = b_neg ? -i_operand_b : i_operand_b;
        div_ovf  = a_signed && (i_operand_a == {1'b1, {(DATA_W-1){1'b0}}}) && (i_operand_b == '1);
    end

    // A borrow out of the trial subtraction means the shifted remainder was below the divisor.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvs_q} : {(DATA_W+1){1'b0}});
        div_shift = {acc_q, quo_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, dvs_q};
        prod      = {acc_q, quo_q};
        prod_fix  = qneg_q ? -prod : prod;
        q_fix     = qneg_q ? -quo_q : quo_q;
        r_fix     = rneg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_d   = i_alu_op;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (is_mul) begin
                        acc_d   = '0;
                        quo_d   = b_mag;
                        dvs_d   = a_mag;
                        cnt_d   = CNT_W'(DATA_W);
                        state_d = S_MUL;
                    end else if (is_div) begin
                        if (i_operand_b == '0) begin
                            quo_d   = '1;
                            acc_d   = i_operand_a;
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = S_FIX;
                        end else if (div_ovf) begin
                            quo_d   = i_operand_a;
                            acc_d   = '0;
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = S_FIX;
                        end else begin
                            acc_d   = '0;
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            cnt_d   = CNT_W'(DATA_W);
                            state_d = S_DIV;
                        end
                    end else begin
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
                end else if ((state_q == S_DONE) && i_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                {acc_d, quo_d} = {mul_sum, quo_q[DATA_W-1:1]};
                cnt_d          = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (div_diff[DATA_W]) begin
                    acc_d = div_shift[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end else begin
                    acc_d = div_diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                case (op_q)
                    OP_MUL:                       result_d = prod_fix[DATA_W-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*DATA_W-1:DATA_W];
                    OP_DIV, OP_DIVU:              result_d = q_fix;
                    default:                      result_d = r_fix;
                endcase
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything, including a FIX that would otherwise publish a result.
        if (i_flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // NOTE: non-blocking assignments so every flop samples its _d value from the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expectations are queued at accept and checked when results are consumed.
module tb_alu_seq;

    localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3,  SLTU = 5'd4;
    localparam logic [4:0] XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7,  OR_ = 5'd8,  AND_ = 5'd9;
    localparam logic [4:0] OPB = 5'd10, MUL = 5'd11, MULH = 5'd12, MULHSU = 5'd13, MULHU = 5'd14;
    localparam logic [4:0] DIV = 5'd15, DIVU = 5'd16, REM = 5'd17, REMU = 5'd18;

    logic        clk = 1'b0;
    logic        i_rst, i_flush, i_valid, i_ready;
    logic [4:0]  i_alu_op;
    logic [31:0] i_operand_a, i_operand_b;
    logic        o_ready, o_valid;
    logic [31:0] o_alu_data;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          acc_edge;
        int          lat;
        bit          seen;
    } item_t;

    item_t sb[$];
    int    cyc   = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    alu_seq #(.DATA_W(32)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_alu_op   (i_alu_op),
        .i_operand_a(i_operand_a),
        .i_operand_b(i_operand_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_alu_data (o_alu_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Latency is checked the first time a result shows; data is checked when it is consumed.
    always @(negedge clk) begin
        if (!i_rst && o_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", {31'b0, o_valid}, 32'd0);
            end else begin
                if (!sb[0].seen) begin
                    sb[0].seen = 1'b1;
                    check({sb[0].tag, "_lat"}, 32'(cyc - sb[0].acc_edge + 1), 32'(sb[0].lat));
                end
                if (i_ready && !i_flush) begin
                    check(sb[0].tag, o_alu_data, sb[0].exp);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        item_t it;
        bit    done;
        done        = 1'b0;
        i_valid     = 1'b1;
        i_alu_op    = op;
        i_operand_a = a;
        i_operand_b = b;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (o_ready && !i_flush) begin
                it.tag      = tag;
                it.exp      = exp;
                it.acc_edge = cyc + 1;
                it.lat      = lat;
                it.seen     = 1'b0;
                sb.push_back(it);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!done) check({tag, "_accept_timeout"}, {31'b0, o_ready}, 32'd1);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc && !o_valid; k++) begin
            @(posedge clk);
            #1;
        end
        if (!o_valid) check({tag, "_valid_timeout"}, {31'b0, o_valid}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_alu_op = '0; i_operand_a = '0; i_operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_data",  o_alu_data, 32'd0);
        i_rst = 1'b0;
        @(posedge clk);
        #1;

        t0 = cyc;
        issue("add",  ADD, 32'd5, 32'd7, 32'h0000000C, 1);
        issue("sub",  SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1);
        issue("sra",  SRA, 32'h80000000, 32'd4, 32'hF8000000, 1);
        check("b2b_cycles", 32'(cyc - t0), 32'd3);
        wait_drain(20);

        issue("sll",   SLL,  32'd1, 32'd35, 32'd8, 1);
        issue("slt",   SLT,  32'hFFFFFFFF, 32'd0, 32'd1, 1);
        issue("sltu",  SLTU, 32'hFFFFFFFF, 32'd0, 32'd0, 1);
        issue("srl",   SRL,  32'h80000000, 32'd4, 32'h08000000, 1);
        issue("xor",   XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        issue("or",    OR_,  32'hF0000000, 32'h0000000F, 32'hF000000F, 1);
        issue("and",   AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
        issue("opb",   OPB,  32'h12345678, 32'hCAFEBABE, 32'hCAFEBABE, 1);
        issue("op20",  5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1);
        wait_drain(20);

        issue("mulh",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
        issue("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        issue("mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        issue("mul",    MUL,    32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 34);
        issue("div",    DIV,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        issue("rem",    REM,    32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        issue("divu",   DIVU,   32'd100, 32'd7, 32'd14, 34);
        issue("remu",   REMU,   32'd100, 32'd7, 32'd2, 34);
        issue("div_neg_b", DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        issue("rem_neg_b", REM, 32'd7, 32'hFFFFFFFE, 32'd1, 34);
        issue("divu_big", DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);
        issue("div_ovf",  DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        issue("rem_ovf",  REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 2);
        issue("divu_z",   DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 2);
        issue("rem_z",    REM,  32'd9, 32'd0, 32'd9, 2);
        wait_drain(100);

        // Back-pressure: result must hold and new issues must be refused.
        i_ready = 1'b0;
        issue("div_bp", DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34);
        wait_valid("div_bp", 60);
        i_valid = 1'b1; i_alu_op = ADD; i_operand_a = 32'd2; i_operand_b = 32'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, o_valid}, 32'd1);
            check("bp_data",  o_alu_data, 32'hFFFFFFF2);
            check("bp_ready", {31'b0, o_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        issue("add_after_bp", ADD, 32'd2, 32'd3, 32'd5, 1);
        wait_drain(20);

        // Flush ten cycles into a multiply.
        issue("mul_flushed", MUL, 32'd3, 32'd4, 32'd12, 34);
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        sb.delete();
        check("flush_valid", {31'b0, o_valid}, 32'd0);
        check("flush_ready", {31'b0, o_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_result", {31'b0, o_valid}, 32'd0);
        issue("add_after_flush", ADD, 32'd1, 32'd1, 32'd2, 1);
        wait_drain(20);

        // Flush in DONE beats both i_ready and a same-cycle accept.
        i_ready = 1'b0;
        issue("add_dropped", ADD, 32'd4, 32'd4, 32'd8, 1);
        wait_valid("add_dropped", 5);
        i_flush = 1'b1; i_ready = 1'b1; i_valid = 1'b1;
        i_alu_op = ADD; i_operand_a = 32'd9; i_operand_b = 32'd9;
        @(posedge clk);
        #1;
        i_flush = 1'b0; i_valid = 1'b0;
        sb.delete();
        check("flush_done_valid", {31'b0, o_valid}, 32'd0);
        check("flush_done_data",  o_alu_data, 32'd8);
        @(posedge clk);
        #1;
        check("flush_done_no_accept", {31'b0, o_valid}, 32'd0);

        // Asynchronous reset in the middle of a divide.
        issue("div_reset", DIVU, 32'd100, 32'd7, 32'd14, 34);
        repeat (5) @(posedge clk);
        #1;
        i_rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, o_valid}, 32'd0);
        check("arst_ready", {31'b0, o_ready}, 32'd1);
        check("arst_data",  o_alu_data, 32'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        issue("remu_after_rst", REMU, 32'd1000, 32'd33, 32'd10, 34);
        wait_drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
